// File: rtl/execute_stage_pipelined.sv
// Pipelined EX stage: forwarding muxes, ALU, iterative shift-add multiplier and a
// valid/ready EX/MEM output register.
module execute_stage_pipelined #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              O_ready,
  input  logic              in_flush,
  input  logic [DATA_W-1:0] in_Read_Data_1,
  input  logic [DATA_W-1:0] in_Read_Data_2,
  input  logic [DATA_W-1:0] in_Immediate,
  input  logic [3:0]        in_Function,
  input  logic              in_ALUSrc,
  input  logic [1:0]        in_ALUOp,
  input  logic [DATA_W-1:0] in_PC_plus_two,
  input  logic              in_RegDest,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_RegWrite,
  input  logic [1:0]        in_FwdA,
  input  logic [1:0]        in_FwdB,
  input  logic [DATA_W-1:0] in_Fwd_MEM_Data,
  input  logic [DATA_W-1:0] in_Fwd_WB_Data,
  input  logic              in_ready,
  output logic              O_valid,
  output logic [DATA_W-1:0] O_ALUResult,
  output logic              O_Zero,
  output logic [DATA_W-1:0] O_BranchTarget,
  output logic [REG_W-1:0]  O_WriteRegister,
  output logic              O_RegWrite,
  output logic              O_Busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mcand_q, mcand_d;
  logic [DATA_W-1:0]  mplier_q, mplier_d;
  logic [DATA_W-1:0]  prod_q, prod_d;
  logic [DATA_W-1:0]  pendTarget_q, pendTarget_d;
  logic [REG_W-1:0]   pendWreg_q, pendWreg_d;
  logic               pendRegWrite_q, pendRegWrite_d;

  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               zero_q, zero_d;
  logic [DATA_W-1:0]  target_q, target_d;
  logic [REG_W-1:0]   wreg_q, wreg_d;
  logic               regWrite_q, regWrite_d;

  logic [DATA_W-1:0]  opA, fwdB, opB, aluResult, branchTarget, stepProd, finalProd;
  logic [REG_W-1:0]   wregSel;
  logic               isMul, ready, accept, slotFree;

  always_comb begin
    unique case (in_FwdA)
      2'b01:   opA = in_Fwd_MEM_Data;
      2'b10:   opA = in_Fwd_WB_Data;
      default: opA = in_Read_Data_1;
    endcase
    unique case (in_FwdB)
      2'b01:   fwdB = in_Fwd_MEM_Data;
      2'b10:   fwdB = in_Fwd_WB_Data;
      default: fwdB = in_Read_Data_2;
    endcase
  end

  assign opB          = in_ALUSrc ? in_Immediate : fwdB;
  assign branchTarget = in_PC_plus_two + {in_Immediate[DATA_W-2:0], 1'b0};
  assign wregSel      = in_RegDest ? in_rd : in_rt;
  assign isMul        = MUL_EN && (in_ALUOp == 2'b10) && (in_Function == 4'b0111);

  always_comb begin
    aluResult = '0;
    unique case (in_ALUOp)
      2'b00: aluResult = opA + opB;
      2'b01: aluResult = opA - opB;
      2'b11: aluResult = opA | opB;
      default: begin
        unique case (in_Function)
          4'b0000: aluResult = opA + opB;
          4'b0001: aluResult = opA - opB;
          4'b0010: aluResult = opA & opB;
          4'b0011: aluResult = opA | opB;
          4'b0100: aluResult = ($signed(opA) < $signed(opB)) ? DATA_W'(1) : '0;
          4'b0101: aluResult = opA << opB[3:0];
          4'b0110: aluResult = opA >> opB[3:0];
          default: aluResult = '0;
        endcase
      end
    endcase
  end

  assign ready    = (state_q == IDLE) && (!valid_q || in_ready) && !in_flush;
  assign accept   = in_valid && ready;
  assign slotFree = !valid_q || in_ready;
  assign stepProd = prod_q + (mplier_q[0] ? mcand_q : '0);
  // The last shift-add step is folded into the load so the product lands DATA_W edges after accept.
  assign finalProd = (cnt_q == CNT_W'(1)) ? stepProd : prod_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    prod_d         = prod_q;
    pendTarget_d   = pendTarget_q;
    pendWreg_d     = pendWreg_q;
    pendRegWrite_d = pendRegWrite_q;
    valid_d        = valid_q;
    result_d       = result_q;
    zero_d         = zero_q;
    target_d       = target_q;
    wreg_d         = wreg_q;
    regWrite_d     = regWrite_q;

    if (in_flush) begin
      valid_d = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (valid_q && in_ready) valid_d = 1'b0;
      if (accept) begin
        if (isMul) begin
          state_d        = MUL;
          cnt_d          = CNT_W'(DATA_W);
          mcand_d        = opA;
          mplier_d       = opB;
          prod_d         = '0;
          pendTarget_d   = branchTarget;
          pendWreg_d     = wregSel;
          pendRegWrite_d = in_RegWrite;
        end else begin
          valid_d    = 1'b1;
          result_d   = aluResult;
          zero_d     = (aluResult == '0);
          target_d   = branchTarget;
          wreg_d     = wregSel;
          regWrite_d = in_RegWrite;
        end
      end
    end else begin
      if (valid_q && in_ready) valid_d = 1'b0;
      if (cnt_q != '0) begin
        prod_d   = stepProd;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
      end
      if ((cnt_q <= CNT_W'(1)) && slotFree) begin
        state_d    = IDLE;
        cnt_d      = '0;
        valid_d    = 1'b1;
        result_d   = finalProd;
        zero_d     = (finalProd == '0);
        target_d   = pendTarget_q;
        wreg_d     = pendWreg_q;
        regWrite_d = pendRegWrite_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      prod_q         <= '0;
      pendTarget_q   <= '0;
      pendWreg_q     <= '0;
      pendRegWrite_q <= 1'b0;
      valid_q        <= 1'b0;
      result_q       <= '0;
      zero_q         <= 1'b0;
      target_q       <= '0;
      wreg_q         <= '0;
      regWrite_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      prod_q         <= prod_d;
      pendTarget_q   <= pendTarget_d;
      pendWreg_q     <= pendWreg_d;
      pendRegWrite_q <= pendRegWrite_d;
      valid_q        <= valid_d;
      result_q       <= result_d;
      zero_q         <= zero_d;
      target_q       <= target_d;
      wreg_q         <= wreg_d;
      regWrite_q     <= regWrite_d;
    end
  end

  assign O_ready         = ready;
  assign O_valid         = valid_q;
  assign O_ALUResult     = result_q;
  assign O_Zero          = zero_q;
  assign O_BranchTarget  = target_q;
  assign O_WriteRegister = wreg_q;
  assign O_RegWrite      = regWrite_q;
  assign O_Busy          = (state_q == MUL);

endmodule

// File: tb/tb_execute_stage_pipelined.sv
// Directed bench for execute_stage_pipelined with hand-computed expected values.
module tb_execute_stage_pipelined;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid, inFlush, inReady;
  logic [15:0] rd1, rd2, imm, pcPlusTwo, memData, wbData;
  logic [3:0]  funct;
  logic        aluSrc, regDest, regWriteIn;
  logic [1:0]  aluOp, fwdA, fwdB;
  logic [2:0]  rt, rd;
  logic        oReady, oValid, oZero, oRegWrite, oBusy;
  logic [15:0] oResult, oTarget;
  logic [2:0]  oWreg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage_pipelined dut (
    .clk             (clk),
    .rst_n           (rstN),
    .in_valid        (inValid),
    .O_ready         (oReady),
    .in_flush        (inFlush),
    .in_Read_Data_1  (rd1),
    .in_Read_Data_2  (rd2),
    .in_Immediate    (imm),
    .in_Function     (funct),
    .in_ALUSrc       (aluSrc),
    .in_ALUOp        (aluOp),
    .in_PC_plus_two  (pcPlusTwo),
    .in_RegDest      (regDest),
    .in_rt           (rt),
    .in_rd           (rd),
    .in_RegWrite     (regWriteIn),
    .in_FwdA         (fwdA),
    .in_FwdB         (fwdB),
    .in_Fwd_MEM_Data (memData),
    .in_Fwd_WB_Data  (wbData),
    .in_ready        (inReady),
    .O_valid         (oValid),
    .O_ALUResult     (oResult),
    .O_Zero          (oZero),
    .O_BranchTarget  (oTarget),
    .O_WriteRegister (oWreg),
    .O_RegWrite      (oRegWrite),
    .O_Busy          (oBusy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [15:0] im,
                               input logic [1:0] op, input logic [3:0] fn, input logic src,
                               input logic [15:0] pc, input logic dst, input logic [2:0] rtIn,
                               input logic [2:0] rdIn, input logic [1:0] fa, input logic [1:0] fb);
    rd1 = a; rd2 = b; imm = im; aluOp = op; funct = fn; aluSrc = src;
    pcPlusTwo = pc; regDest = dst; rt = rtIn; rd = rdIn; fwdA = fa; fwdB = fb;
    regWriteIn = 1'b1;
    inValid = 1'b1;
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0; inValid = 1'b0; inFlush = 1'b0; inReady = 1'b1;
    rd1 = '0; rd2 = '0; imm = '0; pcPlusTwo = '0; memData = '0; wbData = '0;
    funct = '0; aluSrc = 1'b0; regDest = 1'b0; regWriteIn = 1'b0;
    aluOp = '0; fwdA = '0; fwdB = '0; rt = '0; rd = '0;
    #12;
    checkOutput("reset_valid", {31'b0, oValid}, 32'd0);
    checkOutput("reset_result", {16'b0, oResult}, 32'h0);
    checkOutput("reset_busy", {31'b0, oBusy}, 32'd0);
    rstN = 1'b1;
    #1;
    checkOutput("reset_ready", {31'b0, oReady}, 32'd1);

    applyStimulus(16'h0005, 16'h0003, 16'h0000, 2'b10, 4'b0000, 1'b0, 16'h0000, 1'b1, 3'd2, 3'd5, 2'b00, 2'b00);
    tick();
    checkOutput("add_valid", {31'b0, oValid}, 32'd1);
    checkOutput("add_result", {16'b0, oResult}, 32'h0008);
    checkOutput("add_zero", {31'b0, oZero}, 32'd0);
    checkOutput("add_wreg", {29'b0, oWreg}, 32'd5);
    checkOutput("add_regwrite", {31'b0, oRegWrite}, 32'd1);

    memData = 16'h1234;
    applyStimulus(16'h0000, 16'h1234, 16'hFFFE, 2'b01, 4'b0000, 1'b0, 16'h0010, 1'b0, 3'd3, 3'd6, 2'b01, 2'b00);
    tick();
    checkOutput("beq_result", {16'b0, oResult}, 32'h0000);
    checkOutput("beq_zero", {31'b0, oZero}, 32'd1);
    checkOutput("beq_target", {16'b0, oTarget}, 32'h000C);
    checkOutput("beq_wreg", {29'b0, oWreg}, 32'd3);

    wbData = 16'h0007;
    applyStimulus(16'hFFFF, 16'h0000, 16'h0000, 2'b10, 4'b0100, 1'b0, 16'h0000, 1'b1, 3'd0, 3'd1, 2'b00, 2'b10);
    tick();
    checkOutput("slt_signed", {16'b0, oResult}, 32'h0001);
    applyStimulus(16'h0001, 16'h0000, 16'h0013, 2'b10, 4'b0101, 1'b1, 16'h0000, 1'b1, 3'd0, 3'd1, 2'b00, 2'b00);
    tick();
    checkOutput("sll_imm", {16'b0, oResult}, 32'h0008);
    applyStimulus(16'h8000, 16'h0004, 16'h0000, 2'b10, 4'b0110, 1'b0, 16'h0000, 1'b1, 3'd0, 3'd1, 2'b00, 2'b00);
    tick();
    checkOutput("srl", {16'b0, oResult}, 32'h0800);
    applyStimulus(16'h00F0, 16'h0F0F, 16'h0000, 2'b11, 4'b0000, 1'b0, 16'h0000, 1'b1, 3'd0, 3'd1, 2'b00, 2'b00);
    tick();
    checkOutput("or_aluop", {16'b0, oResult}, 32'h0FFF);
    applyStimulus(16'h00F0, 16'h0F3C, 16'h0000, 2'b10, 4'b0010, 1'b0, 16'h0000, 1'b1, 3'd0, 3'd1, 2'b00, 2'b00);
    tick();
    checkOutput("and_funct", {16'b0, oResult}, 32'h0030);
    applyStimulus(16'h1111, 16'h2222, 16'h0000, 2'b10, 4'b1000, 1'b0, 16'h0000, 1'b1, 3'd0, 3'd1, 2'b00, 2'b00);
    tick();
    checkOutput("bad_funct_result", {16'b0, oResult}, 32'h0000);
    checkOutput("bad_funct_zero", {31'b0, oZero}, 32'd1);

    applyStimulus(16'h0012, 16'h0034, 16'h0000, 2'b10, 4'b0111, 1'b0, 16'h0000, 1'b1, 3'd0, 3'd4, 2'b00, 2'b00);
    tick();
    inValid = 1'b0;
    #1;
    checkOutput("mul_busy_start", {31'b0, oBusy}, 32'd1);
    checkOutput("mul_ready_start", {31'b0, oReady}, 32'd0);
    repeat (15) tick();
    checkOutput("mul_busy_last", {31'b0, oBusy}, 32'd1);
    checkOutput("mul_no_early_valid", {31'b0, oValid}, 32'd0);
    tick();
    checkOutput("mul_valid", {31'b0, oValid}, 32'd1);
    checkOutput("mul_result", {16'b0, oResult}, 32'h03A8);
    checkOutput("mul_wreg", {29'b0, oWreg}, 32'd4);
    checkOutput("mul_busy_done", {31'b0, oBusy}, 32'd0);

    applyStimulus(16'h0100, 16'h0100, 16'h0000, 2'b10, 4'b0111, 1'b0, 16'h0000, 1'b1, 3'd0, 3'd2, 2'b00, 2'b00);
    tick();
    inValid = 1'b0;
    repeat (16) tick();
    checkOutput("mul_wrap_result", {16'b0, oResult}, 32'h0000);
    checkOutput("mul_wrap_zero", {31'b0, oZero}, 32'd1);

    inReady = 1'b0;
    applyStimulus(16'h0002, 16'h0003, 16'h0000, 2'b00, 4'b0000, 1'b0, 16'h0000, 1'b1, 3'd0, 3'd7, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_valid_held", {31'b0, oValid}, 32'd1);
      checkOutput("bp_result_held", {16'b0, oResult}, 32'h0000);
      checkOutput("bp_ready_low", {31'b0, oReady}, 32'd0);
    end
    inReady = 1'b1;
    #1;
    checkOutput("bp_ready_high", {31'b0, oReady}, 32'd1);
    tick();
    checkOutput("bp_load_valid", {31'b0, oValid}, 32'd1);
    checkOutput("bp_load_result", {16'b0, oResult}, 32'h0005);
    inValid = 1'b0;
    tick();
    checkOutput("drain_valid", {31'b0, oValid}, 32'd0);

    applyStimulus(16'h0003, 16'h0004, 16'h0000, 2'b10, 4'b0111, 1'b0, 16'h0000, 1'b1, 3'd0, 3'd1, 2'b00, 2'b00);
    tick();
    inValid = 1'b0;
    repeat (4) tick();
    inFlush = 1'b1;
    tick();
    inFlush = 1'b0;
    #1;
    checkOutput("flush_valid", {31'b0, oValid}, 32'd0);
    checkOutput("flush_busy", {31'b0, oBusy}, 32'd0);
    checkOutput("flush_ready", {31'b0, oReady}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("flush_no_product", {31'b0, oValid}, 32'd0);
    end

    applyStimulus(16'h0009, 16'h0009, 16'h0000, 2'b10, 4'b0111, 1'b0, 16'h0000, 1'b1, 3'd0, 3'd3, 2'b00, 2'b00);
    tick();
    inValid = 1'b0;
    repeat (3) tick();
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("areset_busy", {31'b0, oBusy}, 32'd0);
    checkOutput("areset_valid", {31'b0, oValid}, 32'd0);
    checkOutput("areset_result", {16'b0, oResult}, 32'h0000);
    #1;
    rstN = 1'b1;
    #1;
    checkOutput("areset_ready", {31'b0, oReady}, 32'd1);
    applyStimulus(16'h0001, 16'h0001, 16'h0000, 2'b00, 4'b0000, 1'b0, 16'h0000, 1'b1, 3'd0, 3'd1, 2'b00, 2'b00);
    tick();
    inValid = 1'b0;
    checkOutput("post_reset_add", {16'b0, oResult}, 32'h0002);
    checkOutput("post_reset_valid", {31'b0, oValid}, 32'd1);
    repeat (20) tick();
    checkOutput("no_late_product", {16'b0, oResult}, 32'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
